// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU 2-entry result queues, round-robin grant onto a
// registered CDB, and age-based squash of younger results on branch mispredict.
module cdb_arbiter #(
  parameter int N_FU   = 3,
  parameter int DEPTH  = 2,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_FU-1:0]          fu_valid,
  input  logic [N_FU*PREG_W-1:0]   fu_pd,
  input  logic [N_FU*ROB_W-1:0]    fu_rob,
  input  logic [N_FU*DATA_W-1:0]   fu_data,
  output logic [N_FU-1:0]          fu_stall,
  input  logic                     mispredict,
  input  logic [ROB_W-1:0]         mispredict_tag,
  input  logic [ROB_W-1:0]         rob_head,
  output logic                     cdb_valid,
  output logic [PREG_W-1:0]        cdb_ps,
  output logic [ROB_W-1:0]         cdb_rob,
  output logic [DATA_W-1:0]        cdb_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           q_q   [N_FU][DEPTH];
  entry_t           q_d   [N_FU][DEPTH];
  logic [CNT_W-1:0] cnt_q [N_FU];
  logic [CNT_W-1:0] cnt_d [N_FU];
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  entry_t           cdb_q, cdb_d;
  logic             grant_valid;
  logic [N_FU-1:0]  grant_oh;

  // Modulo distance from the ROB head makes the compare immune to index wrap.
  function automatic logic is_younger(input logic [ROB_W-1:0] rob,
                                      input logic [ROB_W-1:0] tag,
                                      input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] age_rob;
    logic [ROB_W-1:0] age_tag;
    age_rob = rob - head;
    age_tag = tag - head;
    return age_rob > age_tag;
  endfunction

  always_comb begin
    for (int i = 0; i < N_FU; i++) fu_stall[i] = (cnt_q[i] == CNT_W'(DEPTH));
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_oh    = '0;
    if (!mispredict) begin
      for (int k = 0; k < N_FU; k++) begin
        for (int j = 0; j < N_FU; j++) begin
          if (!grant_valid && cnt_q[j] != '0 && j == (int'(rr_ptr_q) + k) % N_FU) begin
            grant_valid = 1'b1;
            grant_oh[j] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    int   fill;
    logic push;
    for (int i = 0; i < N_FU; i++) begin
      q_d[i] = q_q[i];
      fill   = 0;
      // Keep survivors in order, dropping the popped head and squashed entries.
      for (int s = 0; s < DEPTH; s++) begin
        if (s < int'(cnt_q[i]) && !(grant_oh[i] && s == 0) &&
            !(mispredict && is_younger(q_q[i][s].rob, mispredict_tag, rob_head))) begin
          for (int d = 0; d < DEPTH; d++) if (d == fill) q_d[i][d] = q_q[i][s];
          fill++;
        end
      end
      push = fu_valid[i] && !fu_stall[i] &&
             !(mispredict && is_younger(fu_rob[i*ROB_W +: ROB_W], mispredict_tag, rob_head));
      if (push) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (d == fill) begin
            q_d[i][d].pd   = fu_pd[i*PREG_W +: PREG_W];
            q_d[i][d].rob  = fu_rob[i*ROB_W +: ROB_W];
            q_d[i][d].data = fu_data[i*DATA_W +: DATA_W];
          end
        end
        fill++;
      end
      cnt_d[i] = CNT_W'(fill);
    end
  end

  // A mispredict cycle never grants, so a younger broadcast cannot be extended.
  always_comb begin
    cdb_valid_d = grant_valid;
    cdb_d       = cdb_q;
    rr_ptr_d    = rr_ptr_q;
    for (int j = 0; j < N_FU; j++) begin
      if (grant_oh[j]) begin
        cdb_d    = q_q[j][0];
        rr_ptr_d = RR_W'((j + 1) % N_FU);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_FU; i++) cnt_q[i] <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
    end
  end

  // NOTE: queue payload storage is not reset; the counts alone define validity.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_ps    = cdb_q.pd;
  assign cdb_rob   = cdb_q.rob;
  assign cdb_data  = cdb_q.data;

endmodule
